// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - two-port SRAM access arbiter; optional feature macro ARB_ROUND_ROBIN_EN
module sram_access_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int SEQ_DELAY = 3,
    parameter int TIMEOUT   = 31,
    parameter int GAP       = 2
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              AReq,
    input  logic              AWr,
    input  logic [ADDR_W-1:0] AAddr,
    input  logic [DATA_W-1:0] AWData,
    output logic              AAck,
    output logic [DATA_W-1:0] ARData,
    input  logic              BReq,
    input  logic              BWr,
    input  logic [ADDR_W-1:0] BAddr,
    input  logic [DATA_W-1:0] BWData,
    output logic              BAck,
    output logic [DATA_W-1:0] BRData,
    output logic              Err,
    output logic              SeqStart,
    output logic              SeqRead,
    output logic              SeqWrite,
    output logic [2:0]        SeqDelay,
    output logic              SeqExtend,
    input  logic              SeqCE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDOut,
    output logic              MemDOE,
    input  logic [DATA_W-1:0] MemDIn,
    output logic [1:0]        Grant
);

    localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);
    localparam logic [1:0] GAP_LAST  = 2'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        timer_q, timer_d;
    logic [1:0]        gap_q, gap_d;
    logic [1:0]        grant_q, grant_d;
    logic              seq_read_q, seq_read_d;
    logic              seq_write_q, seq_write_d;
    logic              mem_doe_q, mem_doe_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              pick_b;
    logic              sel_wr;
    logic              go_release;
    logic              cycle_end;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_b_q, last_b_d;
`endif

    // Arbitration: which requester wins if a grant is made this cycle
    always_comb begin
        pick_b = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        pick_b = BReq & (~AReq | ~last_b_q);
`else
        pick_b = BReq & ~AReq;
`endif
        sel_wr = pick_b ? BWr : AWr;
    end

    // Next-state logic and registered output values
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        grant_d     = grant_q;
        seq_read_d  = seq_read_q;
        seq_write_d = seq_write_q;
        mem_doe_d   = mem_doe_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        err_d       = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        go_release  = 1'b0;
        cycle_end   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (AReq | BReq) begin
                    grant_d     = pick_b ? 2'b10 : 2'b01;
                    mem_addr_d  = pick_b ? BAddr : AAddr;
                    mem_dout_d  = pick_b ? BWData : AWData;
                    seq_read_d  = ~sel_wr;
                    seq_write_d = sel_wr;
                    mem_doe_d   = sel_wr;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!SeqCE) begin
                    timer_d = '0;
                    state_d = ST_WAIT_HIGH;
                end else if (timer_q == TIMEOUT_C) begin
                    err_d      = 1'b1;
                    go_release = 1'b1;
                end else begin
                    timer_d = timer_q + 5'd1;
                end
            end
            ST_WAIT_HIGH: begin
                if (SeqCE) begin
                    // CE has returned high: the generator finished the access
                    a_ack_d    = grant_q[0];
                    b_ack_d    = grant_q[1];
                    if (grant_q[0] && seq_read_q) a_rdata_d = MemDIn;
                    if (grant_q[1] && seq_read_q) b_rdata_d = MemDIn;
                    go_release = 1'b1;
                end else if (timer_q == TIMEOUT_C) begin
                    err_d      = 1'b1;
                    go_release = 1'b1;
                end else begin
                    timer_d = timer_q + 5'd1;
                end
            end
            ST_RELEASE: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (go_release) begin
            cycle_end   = 1'b1;
            state_d     = ST_RELEASE;
            gap_d       = '0;
            grant_d     = 2'b00;
            seq_read_d  = 1'b0;
            seq_write_d = 1'b0;
            mem_doe_d   = 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the last port served (by ack or abort) for round-robin fairness
    always_comb begin
        last_b_d = last_b_q;
        if (cycle_end) last_b_d = grant_q[1];
    end
`endif

    // State and output registers; reset drops every strobe at once
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            gap_q       <= '0;
            grant_q     <= 2'b00;
            seq_read_q  <= 1'b0;
            seq_write_q <= 1'b0;
            mem_doe_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            grant_q     <= grant_d;
            seq_read_q  <= seq_read_d;
            seq_write_q <= seq_write_d;
            mem_doe_q   <= mem_doe_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            err_q       <= err_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q    <= last_b_d;
`endif
        end
    end

    // StartCycle stays high from START until the cycle is released
    assign SeqStart  = (state_q == ST_START) || (state_q == ST_WAIT_LOW) ||
                       (state_q == ST_WAIT_HIGH);
    assign SeqRead   = seq_read_q;
    assign SeqWrite  = seq_write_q;
    assign SeqDelay  = 3'(SEQ_DELAY);
    assign SeqExtend = 1'b0;
    assign MemAddr   = mem_addr_q;
    assign MemDOut   = mem_dout_q;
    assign MemDOE    = mem_doe_q;
    assign Grant     = grant_q;
    assign AAck      = a_ack_q;
    assign BAck      = b_ack_q;
    assign ARData    = a_rdata_q;
    assign BRData    = b_rdata_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - scoreboard bench for sram_access_arbiter
module tb_sram_access_arbiter;

    logic        Clk, Reset_N;
    logic        AReq, AWr, BReq, BWr;
    logic [15:0] AAddr, BAddr;
    logic [7:0]  AWData, BWData;
    logic        AAck, BAck, Err;
    logic [7:0]  ARData, BRData;
    logic        SeqStart, SeqRead, SeqWrite, SeqExtend, SeqCE;
    logic [2:0]  SeqDelay;
    logic [15:0] MemAddr;
    logic [7:0]  MemDOut, MemDIn;
    logic        MemDOE;
    logic [1:0]  Grant;

    sram_access_arbiter dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .AReq(AReq), .AWr(AWr), .AAddr(AAddr), .AWData(AWData), .AAck(AAck), .ARData(ARData),
        .BReq(BReq), .BWr(BWr), .BAddr(BAddr), .BWData(BWData), .BAck(BAck), .BRData(BRData),
        .Err(Err), .SeqStart(SeqStart), .SeqRead(SeqRead), .SeqWrite(SeqWrite),
        .SeqDelay(SeqDelay), .SeqExtend(SeqExtend), .SeqCE(SeqCE),
        .MemAddr(MemAddr), .MemDOut(MemDOut), .MemDOE(MemDOE), .MemDIn(MemDIn), .Grant(Grant)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // kind: 0 = A ack, 1 = B ack, 2 = Err
    typedef struct packed {
        logic [1:0] kind;
        logic       is_read;
        logic [7:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    // Generator model: CE low for 3 cycles shortly after StartCycle, or stuck high
    logic       gen_stuck;
    logic       gen_done;
    logic [3:0] gen_cnt;
    always @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            gen_cnt  <= 4'd0;
            gen_done <= 1'b0;
            SeqCE    <= 1'b1;
        end else if (!SeqStart) begin
            gen_cnt  <= 4'd0;
            gen_done <= 1'b0;
            SeqCE    <= 1'b1;
        end else if (!gen_done && !gen_stuck) begin
            gen_cnt <= gen_cnt + 4'd1;
            if (gen_cnt == 4'd1) SeqCE <= 1'b0;
            if (gen_cnt == 4'd4) begin
                SeqCE    <= 1'b1;
                gen_done <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic is_read, input logic [7:0] rdata);
        exp_t e;
        e.kind = kind;
        e.is_read = is_read;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Monitor: every Ack/Err pulse is matched against the scoreboard
    always @(negedge Clk) begin
        if (Reset_N && (AAck || BAck || Err)) begin
            logic [1:0] kind;
            exp_t e;
            kind = AAck ? 2'd0 : (BAck ? 2'd1 : 2'd2);
            checks++;
            if ((32'(AAck) + 32'(BAck) + 32'(Err)) != 1) begin
                errors++;
                $display("FAIL sb_multi: AAck=%0b BAck=%0b Err=%0b required one", AAck, BAck, Err);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: event kind %0d, required none", kind);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind) begin
                    errors++;
                    $display("FAIL sb_kind: got %0d required %0d", kind, e.kind);
                end else if (e.is_read) begin
                    checks++;
                    if ((kind == 2'd0 ? ARData : BRData) !== e.rdata) begin
                        errors++;
                        $display("FAIL sb_rdata: got 0x%0h required 0x%0h",
                                 (kind == 2'd0 ? ARData : BRData), e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  starts, k, err_k, acks, low_run, min_low, pulses;
        bit  got, prev_start, doe_seen, rd_ok, wr_ok;

        Reset_N = 1'b0; AReq = 0; AWr = 0; AAddr = 0; AWData = 0;
        BReq = 0; BWr = 0; BAddr = 0; BWData = 0; MemDIn = 8'h5A; gen_stuck = 0;
        repeat (3) @(negedge Clk);
        check("rst_seqstart", 32'(SeqStart), 0);
        check("rst_grant", 32'(Grant), 0);
        check("rst_doe", 32'(MemDOE), 0);
        check("rst_acks_err", {29'd0, AAck, BAck, Err}, 0);
        check("rst_seqdelay", 32'(SeqDelay), 3);
        check("rst_seqextend", 32'(SeqExtend), 0);
        Reset_N = 1'b1;

        // Single A read
        push(2'd0, 1'b1, 8'h5A);
        AReq = 1; AWr = 0; AAddr = 16'h1234;
        starts = 0; prev_start = 0; doe_seen = 0; rd_ok = 1; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge Clk);
            if (SeqStart && !prev_start) starts++;
            prev_start = SeqStart;
            if (MemDOE) doe_seen = 1;
            if (SeqStart && !(SeqRead && !SeqWrite && MemAddr == 16'h1234 && Grant == 2'b01)) rd_ok = 0;
            if (AAck) got = 1;
        end
        check("a_read_done", 32'(got), 1);
        AReq = 0;
        @(negedge Clk);
        check("a_ack_one_cycle", 32'(AAck), 0);
        repeat (5) @(negedge Clk);
        check("a_read_starts", 32'(starts), 1);
        check("a_read_doe_low", 32'(doe_seen), 0);
        check("a_read_sigs", 32'(rd_ok), 1);
        check("a_rdata_held", 32'(ARData), 32'h5A);

        // Single B write
        push(2'd1, 1'b0, 8'h00);
        BReq = 1; BWr = 1; BAddr = 16'h00FF; BWData = 8'hC3;
        got = 0; wr_ok = 1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge Clk);
            if (SeqStart && !(MemDOE && SeqWrite && !SeqRead && MemAddr == 16'h00FF &&
                              MemDOut == 8'hC3 && Grant == 2'b10)) wr_ok = 0;
            if (BAck) got = 1;
        end
        check("b_write_done", 32'(got), 1);
        check("b_write_sigs", 32'(wr_ok), 1);
        check("b_ack_doe_off", 32'(MemDOE), 0);
        BReq = 0;
        @(negedge Clk);
        check("b_gap1_start", 32'(SeqStart), 0);
        @(negedge Clk);
        check("b_gap2_start", 32'(SeqStart), 0);
        repeat (3) @(negedge Clk);

        // Simultaneous requests for four accesses
`ifdef ARB_ROUND_ROBIN_EN
        push(2'd0, 1'b1, 8'h5A); push(2'd1, 1'b1, 8'h5A);
        push(2'd0, 1'b1, 8'h5A); push(2'd1, 1'b1, 8'h5A);
`else
        for (int i = 0; i < 4; i++) push(2'd0, 1'b1, 8'h5A);
`endif
        AReq = 1; AWr = 0; AAddr = 16'h0010; BReq = 1; BWr = 0; BAddr = 16'h0020;
        acks = 0; low_run = 0; min_low = 1000; pulses = 0; prev_start = 0;
        for (int i = 0; i < 300 && acks < 4; i++) begin
            @(negedge Clk);
            if (SeqStart && !prev_start) begin
                if (pulses > 0 && low_run < min_low) min_low = low_run;
                pulses++;
            end
            low_run = SeqStart ? 0 : low_run + 1;
            prev_start = SeqStart;
            if (AAck || BAck) acks++;
        end
        AReq = 0; BReq = 0;
        check("arb_four_acks", 32'(acks), 4);
        check("arb_min_gap", 32'(min_low), 3);
        repeat (6) @(negedge Clk);

        // Timeout: generator never drops CE
        push(2'd2, 1'b0, 8'h00);
        gen_stuck = 1; MemDIn = 8'hEE;
        AReq = 1; AWr = 0; AAddr = 16'h0BAD;
        k = -1; err_k = -1;
        for (int i = 0; i < 100 && err_k < 0; i++) begin
            @(negedge Clk);
            if (k >= 0) k++;
            else if (SeqStart) k = 0;
            if (Err) err_k = k;
        end
        check("timeout_cycles", 32'(err_k), 33);
        check("timeout_rdata_kept", 32'(ARData), 32'h5A);
        gen_stuck = 0; MemDIn = 8'hA7;
        push(2'd0, 1'b1, 8'hA7);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge Clk);
            if (AAck) got = 1;
        end
        check("timeout_retry_done", 32'(got), 1);
        AReq = 0;
        repeat (4) @(negedge Clk);

        // Reset while in WAIT_HIGH during a B write
        BReq = 1; BWr = 1; BAddr = 16'h0042; BWData = 8'h99;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge Clk);
            if (!SeqCE) got = 1;
        end
        check("rst_mid_ce_low", 32'(got), 1);
        @(negedge Clk);
        check("rst_mid_pre_doe", {30'd0, MemDOE, SeqStart}, 3);
        #2 Reset_N = 1'b0;
        #1;
        check("rst_mid_seqstart", 32'(SeqStart), 0);
        check("rst_mid_doe", 32'(MemDOE), 0);
        check("rst_mid_grant", 32'(Grant), 0);
        check("rst_mid_ack", {30'd0, AAck, BAck}, 0);
        BReq = 0;
        @(negedge Clk);
        Reset_N = 1'b1;
        MemDIn = 8'h3C;
        push(2'd0, 1'b1, 8'h3C);
        AReq = 1; AWr = 0; AAddr = 16'h0777;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge Clk);
            if (AAck) got = 1;
        end
        check("post_reset_done", 32'(got), 1);
        AReq = 0;
        repeat (10) @(negedge Clk);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
